// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the opcode map and the controller state encoding used by
// alu_seq; alu_mdu needs neither, so it stays self-contained.
package alu_pkg;

  // Opcode map. Codes not listed here behave as a pass-through of a_data.
  localparam int OP_ADD  = 0;
  localparam int OP_ADDC = 1;
  localparam int OP_SUBB = 2;
  localparam int OP_INC  = 3;
  localparam int OP_DEC  = 4;
  localparam int OP_ANL  = 5;
  localparam int OP_ORL  = 6;
  localparam int OP_XRL  = 7;
  localparam int OP_CPL  = 8;
  localparam int OP_CLR  = 9;
  localparam int OP_RL   = 10;
  localparam int OP_RLC  = 11;
  localparam int OP_RR   = 12;
  localparam int OP_RRC  = 13;
  localparam int OP_SWAP = 14;
  localparam int OP_DA   = 15;
  localparam int OP_MUL  = 16;
  localparam int OP_DIV  = 17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL_IT = 2'd1,
    ST_DIV_IT = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_mdu.sv
// Iterative unsigned multiply / divide datapath, one bit per clock.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load operands and begin WIDTH iterations
//   div_sel         0 = shift-add multiply, 1 = restoring divide
//   a_data, b_data  operands (multiplier/dividend, multiplicand/divisor)
//   last            high during the final iteration cycle
//   res_lo, res_hi  value the result registers take at the end of this
//                   cycle; on 'last' this is the final product/quotient
//                   (lo) and product-high/remainder (hi)
module alu_mdu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div_sel,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_t;

  // Down-counter: non-zero means an operation is in flight, 1 is the last step.
  assign last = (cnt_q == CNT_W'(1));

  always_comb begin
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_t = {hi_q, lo_q[WIDTH-1]};
    if (div_q) begin
      // Partial remainder is always < divisor, so WIDTH bits suffice.
      if (rem_t >= {1'b0, b_q}) begin
        res_hi = rem_t[WIDTH-1:0] - b_q;
        res_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        res_hi = rem_t[WIDTH-1:0];
        res_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Multiplier bits shift out of lo while product bits shift in from hi.
      {res_hi, res_lo} = {sum, lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      hi_q  <= '0;
      lo_q  <= a_data;
      b_q   <= b_data;
      div_q <= div_sel;
      cnt_q <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      hi_q  <= res_hi;
      lo_q  <= res_lo;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential 8051-style ALU: single-cycle ops complete in one clock,
// MUL/DIV iterate WIDTH clocks in alu_mdu. Results are held until the
// next done pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    request, accepted only while idle
//   alu_op, a_data, b_data   opcode and operands (sampled on acceptance)
//   c_in, ac_in              carry / auxiliary-carry in
//   busy                     operation in progress (through done cycle)
//   done                     one-cycle completion pulse
//   ans, ans_hi              result low / high (product hi, remainder)
//   c_out, ac_out, ov_out    result flags
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_MUL_IT | multiply iterating in alu_mdu
// ST_DIV_IT | divide iterating in alu_mdu
// ST_FIN    | results valid, done asserted
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic             c_in,
  input  logic             ac_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans,
  output logic [WIDTH-1:0] ans_hi,
  output logic             c_out,
  output logic             ac_out,
  output logic             ov_out
);

  state_t state_q, state_d;

  logic             is_mul, is_div, accept, mdu_start, mdu_last;
  logic [WIDTH-1:0] mdu_lo, mdu_hi;

  logic             cin_add;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] da_val;
  logic [WIDTH:0]   da_tmp;
  logic             da_c;
  logic [WIDTH-1:0] r_ans, r_hi;
  logic             r_c, r_ac, r_ov;

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign is_mul    = (alu_op == OP_W'(OP_MUL));
  assign is_div    = (alu_op == OP_W'(OP_DIV));
  assign accept    = (state_q == ST_IDLE) && start;
  // Divide by zero never reaches the iterative unit.
  assign mdu_start = accept && (is_mul || (is_div && (b_data != '0)));

  alu_mdu #(.WIDTH(WIDTH)) u_mdu (
    .clk     (clk),
    .rst     (rst),
    .start   (mdu_start),
    .div_sel (is_div),
    .a_data  (a_data),
    .b_data  (b_data),
    .last    (mdu_last),
    .res_lo  (mdu_lo),
    .res_hi  (mdu_hi)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mdu_start) state_d = is_div ? ST_DIV_IT : ST_MUL_IT;
          else           state_d = ST_FIN;
        end
      end
      ST_MUL_IT, ST_DIV_IT: if (mdu_last) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Single-cycle result path, evaluated on the live inputs at acceptance.
  always_comb begin
    cin_add = (alu_op == OP_W'(OP_ADDC)) && c_in;
    sum     = {1'b0, a_data} + {1'b0, b_data} + {{WIDTH{1'b0}}, cin_add};
    dif     = a_data - b_data - {{(WIDTH-1){1'b0}}, c_in};

    // Decimal adjust: nibble 0 honours ac_in, the top nibble honours c_in,
    // and carries out of any nibble ripple into the next.
    da_val = a_data;
    da_c   = c_in;
    da_tmp = '0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      if ((da_val[4*i +: 4] > 4'd9) || ((i == 0) && ac_in) ||
          ((i == WIDTH / 4 - 1) && c_in)) begin
        da_tmp = {1'b0, da_val} + ((WIDTH+1)'(6) << (4 * i));
        da_val = da_tmp[WIDTH-1:0];
        da_c   = da_c | da_tmp[WIDTH];
      end
    end

    r_ans = a_data;
    r_hi  = '0;
    r_c   = c_in;
    r_ac  = ac_in;
    r_ov  = 1'b0;
    case (alu_op)
      OP_W'(OP_ADD), OP_W'(OP_ADDC): begin
        r_ans = sum[WIDTH-1:0];
        r_c   = sum[WIDTH];
        r_ac  = ({1'b0, a_data[3:0]} + {1'b0, b_data[3:0]} + {4'd0, cin_add}) > 5'd15;
        r_ov  = (a_data[WIDTH-1] == b_data[WIDTH-1]) && (sum[WIDTH-1] != a_data[WIDTH-1]);
      end
      OP_W'(OP_SUBB): begin
        r_ans = dif;
        r_c   = {1'b0, a_data} < ({1'b0, b_data} + {{WIDTH{1'b0}}, c_in});
        r_ac  = {1'b0, a_data[3:0]} < ({1'b0, b_data[3:0]} + {4'd0, c_in});
        r_ov  = (a_data[WIDTH-1] != b_data[WIDTH-1]) && (dif[WIDTH-1] != a_data[WIDTH-1]);
      end
      OP_W'(OP_INC):  r_ans = a_data + WIDTH'(1);
      OP_W'(OP_DEC):  r_ans = a_data - WIDTH'(1);
      OP_W'(OP_ANL):  r_ans = a_data & b_data;
      OP_W'(OP_ORL):  r_ans = a_data | b_data;
      OP_W'(OP_XRL):  r_ans = a_data ^ b_data;
      OP_W'(OP_CPL):  r_ans = ~a_data;
      OP_W'(OP_CLR):  r_ans = '0;
      OP_W'(OP_RL):   r_ans = {a_data[WIDTH-2:0], a_data[WIDTH-1]};
      OP_W'(OP_RR):   r_ans = {a_data[0], a_data[WIDTH-1:1]};
      OP_W'(OP_RLC): begin
        r_ans = {a_data[WIDTH-2:0], c_in};
        r_c   = a_data[WIDTH-1];
      end
      OP_W'(OP_RRC): begin
        r_ans = {c_in, a_data[WIDTH-1:1]};
        r_c   = a_data[0];
      end
      OP_W'(OP_SWAP): r_ans = {a_data[WIDTH/2-1:0], a_data[WIDTH-1:WIDTH/2]};
      OP_W'(OP_DA): begin
        r_ans = da_val;
        r_c   = da_c;
      end
      OP_W'(OP_DIV): begin
        // Only reached with b_data == 0.
        r_ans = '1;
        r_hi  = a_data;
        r_c   = 1'b0;
        r_ac  = 1'b0;
        r_ov  = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs change only when the op that produces them completes, so they
  // stay stable while a MUL/DIV is iterating.
  always_ff @(posedge clk) begin
    if (rst) begin
      ans    <= '0;
      ans_hi <= '0;
      c_out  <= 1'b0;
      ac_out <= 1'b0;
      ov_out <= 1'b0;
    end else if (accept && !mdu_start) begin
      ans    <= r_ans;
      ans_hi <= r_hi;
      c_out  <= r_c;
      ac_out <= r_ac;
      ov_out <= r_ov;
    end else if (mdu_last) begin
      ans    <= mdu_lo;
      ans_hi <= mdu_hi;
      c_out  <= 1'b0;
      ac_out <= 1'b0;
      ov_out <= (state_q == ST_MUL_IT) && (mdu_hi != '0);
    end
  end

endmodule
